cluster_axilite_cfg_slave: RTL
==============================

CLUSTER_AXILITE_CFG_SLAVE -- requirements
Module: cluster_axilite_cfg_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, AXI-Lite address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, AXI-Lite data width (32 or 64 only).
REQ-003 SHALL have parameter NB_REGS, default 16, number of config registers (power of two, >=2).
REQ-004 SHALL have parameter ID_VALUE, default 64'h0, read-only contents of register 0.
REQ-005 SHALL use one clock and an asynchronous, active-high reset: clk_i  in  1  clock; rst_i  in  1  reset (async, active-high).
REQ-006 SHALL have AW channel ports: aw_addr_i in ADDR_WIDTH; aw_valid_i in 1; aw_ready_o out 1.
REQ-007 SHALL have W channel ports: w_data_i in DATA_WIDTH; w_strb_i in DATA_WIDTH/8; w_valid_i in 1; w_ready_o out 1.
REQ-008 SHALL have B channel ports: b_resp_o out 2; b_valid_o out 1; b_ready_i in 1.
REQ-009 SHALL have AR channel ports: ar_addr_i in ADDR_WIDTH; ar_valid_i in 1; ar_ready_o out 1.
REQ-010 SHALL have R channel ports: r_data_o out DATA_WIDTH; r_resp_o out 2; r_valid_o out 1; r_ready_i in 1.
REQ-011 SHALL have cfg_regs_o out NB_REGS*DATA_WIDTH: all register contents, flattened.
REQ-012 SHALL have cfg_wr_o out 1: one-cycle pulse on each committed register write; cfg_wr_idx_o out clog2(NB_REGS): index of that write.

Function
REQ-013 SHALL decode register index as addr[clog2(DATA_WIDTH/8)+clog2(NB_REGS)-1 : clog2(DATA_WIDTH/8)]; bits above the index field are ignored (window decode done by the crossbar); bits below it are ignored.
REQ-014 Write FSM SHALL have states W_IDLE, W_WAIT_W, W_WAIT_AW, W_RESP.
REQ-015 In W_IDLE, aw_ready_o and w_ready_o SHALL both be 1; AW and W may handshake in the same cycle or in either order.
REQ-016 AW-only handshake -> W_WAIT_W (address latched, aw_ready_o=0); W-only -> W_WAIT_AW (data/strobe latched, w_ready_o=0); both -> commit same cycle, then W_RESP.
REQ-017 On commit, each byte lane with strobe=1 SHALL be updated in the next cycle; cfg_wr_o SHALL pulse in the cycle after the commit handshake.
REQ-018 Write to index 0 SHALL not modify state, SHALL not pulse cfg_wr_o, and SHALL respond SLVERR (2'b10); all other writes respond OKAY (2'b00), including all-zero strobe (no byte changes, cfg_wr_o still pulses).
REQ-019 In W_RESP, b_valid_o=1 and stable until b_ready_i; aw_ready_o=w_ready_o=0; handshake -> W_IDLE. Latency AW+W handshake to b_valid_o: 1 cycle.
REQ-020 Read FSM SHALL have states R_IDLE, R_RESP; ar_ready_o=1 only in R_IDLE.
REQ-021 AR handshake SHALL latch r_data_o (register contents at handshake cycle) and r_resp_o=OKAY, entering R_RESP next cycle; r_valid_o, r_data_o, r_resp_o stable until r_ready_i.
REQ-022 Read of index 0 SHALL return ID_VALUE truncated/zero-extended to DATA_WIDTH.
REQ-023 Read and write FSMs SHALL be independent; read and write committing the same register in the same cycle SHALL return the pre-write value.
REQ-024 No more than one outstanding write and one outstanding read SHALL exist; no combinational path from any valid input to any ready output.

Reset
REQ-025 On rst_i assertion (any time, including mid-transaction): both FSMs to IDLE; registers 1..NB_REGS-1 to 0; b_valid_o=r_valid_o=cfg_wr_o=0; b_resp_o=r_resp_o=0; r_data_o=0; cfg_wr_idx_o=0; in-flight transactions are dropped.
REQ-026 While rst_i=1, aw_ready_o, w_ready_o and ar_ready_o SHALL be 0.

Structure
REQ-027 Response encodings (OKAY, SLVERR) and FSM state enums SHALL reside in pulp_cluster_package.
REQ-028 SHALL be a single module, no sub-modules; byte-lane write merge inline.

Verification
REQ-029 AW addr 0x08 and W data 0xDEAD_BEEF_0000_1111 strb 0xFF in same cycle -> b_valid_o next cycle, OKAY; cfg_wr_o pulse idx 1; read 0x08 returns same data.
REQ-030 W data 0xFF..FF strb 0x0F three cycles before AW addr 0x10 -> reg 2 = 0x0000_0000_FFFF_FFFF, single B OKAY after AW.
REQ-031 Write addr 0x00 -> SLVERR, no cfg_wr_o; read 0x00 -> ID_VALUE, OKAY.
REQ-032 Hold b_ready_i=0 for 5 cycles -> b_valid_o/b_resp_o stable, aw_ready_o=w_ready_o=0 throughout; likewise R with r_ready_i=0.
REQ-033 Same-cycle AR and AW+W to addr 0x18 (old 0x5, new 0x9) -> R data 0x5, then later read 0x9.
REQ-034 Assert rst_i while in W_RESP and R_RESP -> all valids drop asynchronously, registers cleared, next transaction completes normally.

Source files
------------

// File: rtl/pulp_cluster_package.sv
// Shared definitions for the cluster configuration slave.
// Holds the AXI response encodings and the state enumerations
// of the write and read channel FSMs.
package pulp_cluster_package;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT_W,
    W_WAIT_AW,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rd_state_e;

endpackage

// File: rtl/cluster_axilite_cfg_slave.sv
// AXI-Lite slave exposing a bank of NB_REGS configuration registers.
// Register 0 is a read-only identification word (ID_VALUE); registers
// 1..NB_REGS-1 are read/write with byte strobes.
//
// Ports:
//   clk_i, rst_i              clock, asynchronous active-high reset
//   aw_* / w_* / b_*          write address, write data, write response
//   ar_* / r_*                read address, read data
//   cfg_regs_o                all registers flattened, register i at
//                             [i*DATA_WIDTH +: DATA_WIDTH]
//   cfg_wr_o, cfg_wr_idx_o    one-cycle pulse and index of each register
//                             update (writes to register 0 do not pulse)
module cluster_axilite_cfg_slave
  import pulp_cluster_package::*;
#(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NB_REGS    = 16,
  parameter logic [63:0] ID_VALUE   = 64'h0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [ADDR_WIDTH-1:0]         aw_addr_i,
  input  logic                          aw_valid_i,
  output logic                          aw_ready_o,
  input  logic [DATA_WIDTH-1:0]         w_data_i,
  input  logic [DATA_WIDTH/8-1:0]       w_strb_i,
  input  logic                          w_valid_i,
  output logic                          w_ready_o,
  output logic [1:0]                    b_resp_o,
  output logic                          b_valid_o,
  input  logic                          b_ready_i,
  input  logic [ADDR_WIDTH-1:0]         ar_addr_i,
  input  logic                          ar_valid_i,
  output logic                          ar_ready_o,
  output logic [DATA_WIDTH-1:0]         r_data_o,
  output logic [1:0]                    r_resp_o,
  output logic                          r_valid_o,
  input  logic                          r_ready_i,
  output logic [NB_REGS*DATA_WIDTH-1:0] cfg_regs_o,
  output logic                          cfg_wr_o,
  output logic [$clog2(NB_REGS)-1:0]    cfg_wr_idx_o
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam int unsigned IDX_W  = $clog2(NB_REGS);

  // Only the register-index field of an address matters: the crossbar has
  // already decoded the window, and sub-word offsets are ignored.
  function automatic logic [IDX_W-1:0] reg_idx(input logic [ADDR_WIDTH-1:0] addr);
    return addr[OFF_W +: IDX_W];
  endfunction

  logic unused_addr_bits;
  assign unused_addr_bits = ^{aw_addr_i, ar_addr_i};

  wr_state_e wr_state, wr_state_next;
  rd_state_e rd_state, rd_state_next;

  logic                   aw_hs, w_hs, ar_hs;
  logic                   wr_commit, latch_aw, latch_w;
  logic [IDX_W-1:0]       aw_idx_q;
  logic [DATA_WIDTH-1:0]  w_data_q;
  logic [STRB_W-1:0]      w_strb_q;
  logic [IDX_W-1:0]       cm_idx;
  logic [DATA_WIDTH-1:0]  cm_data;
  logic [STRB_W-1:0]      cm_strb;
  logic                   cm_is_id;
  logic [DATA_WIDTH-1:0]  regs_q [1:NB_REGS-1];

  // ---------------------------------------------------------------------------
  // Write channel FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) wr_state <= W_IDLE;
    else       wr_state <= wr_state_next;
  end

  always_comb begin
    wr_state_next = wr_state;
    aw_ready_o    = 1'b0;
    w_ready_o     = 1'b0;
    b_valid_o     = 1'b0;
    latch_aw      = 1'b0;
    latch_w       = 1'b0;
    wr_commit     = 1'b0;

    // Readies depend on state only, never on an incoming valid.
    unique case (wr_state)
      W_IDLE:    begin aw_ready_o = 1'b1; w_ready_o = 1'b1; end
      W_WAIT_W:  w_ready_o  = 1'b1;
      W_WAIT_AW: aw_ready_o = 1'b1;
      W_RESP:    b_valid_o  = 1'b1;
      default:   ;
    endcase
    if (rst_i) begin
      aw_ready_o = 1'b0;
      w_ready_o  = 1'b0;
    end

    aw_hs = aw_valid_i & aw_ready_o;
    w_hs  = w_valid_i & w_ready_o;

    unique case (wr_state)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          wr_commit     = 1'b1;
          wr_state_next = W_RESP;
        end else if (aw_hs) begin
          latch_aw      = 1'b1;
          wr_state_next = W_WAIT_W;
        end else if (w_hs) begin
          latch_w       = 1'b1;
          wr_state_next = W_WAIT_AW;
        end
      end
      W_WAIT_W: begin
        if (w_hs) begin
          wr_commit     = 1'b1;
          wr_state_next = W_RESP;
        end
      end
      W_WAIT_AW: begin
        if (aw_hs) begin
          wr_commit     = 1'b1;
          wr_state_next = W_RESP;
        end
      end
      W_RESP: begin
        if (b_ready_i) wr_state_next = W_IDLE;
      end
      default: wr_state_next = W_IDLE;
    endcase
  end

  // Commit operands: whichever half arrived earlier comes from its latch.
  assign cm_idx   = (wr_state == W_WAIT_W)  ? aw_idx_q : reg_idx(aw_addr_i);
  assign cm_data  = (wr_state == W_WAIT_AW) ? w_data_q : w_data_i;
  assign cm_strb  = (wr_state == W_WAIT_AW) ? w_strb_q : w_strb_i;
  assign cm_is_id = (cm_idx == '0);

  // ---------------------------------------------------------------------------
  // Write datapath: latches, register bank, response and update pulse
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      aw_idx_q     <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      cfg_wr_o     <= 1'b0;
      cfg_wr_idx_o <= '0;
      b_resp_o     <= RESP_OKAY;
      for (int i = 1; i < NB_REGS; i++) regs_q[i] <= '0;
    end else begin
      if (latch_aw) aw_idx_q <= reg_idx(aw_addr_i);
      if (latch_w) begin
        w_data_q <= w_data_i;
        w_strb_q <= w_strb_i;
      end

      cfg_wr_o <= wr_commit & ~cm_is_id;
      if (wr_commit) begin
        b_resp_o <= cm_is_id ? RESP_SLVERR : RESP_OKAY;
        if (!cm_is_id) cfg_wr_idx_o <= cm_idx;
      end

      // Byte-lane merge; a zero strobe still counts as a committed write.
      for (int i = 1; i < NB_REGS; i++) begin
        if (wr_commit && (cm_idx == IDX_W'(i))) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (cm_strb[b]) regs_q[i][8*b +: 8] <= cm_data[8*b +: 8];
          end
        end
      end
    end
  end

  assign cfg_regs_o[DATA_WIDTH-1:0] = ID_VALUE[DATA_WIDTH-1:0];
  for (genvar g = 1; g < NB_REGS; g++) begin : g_flat
    assign cfg_regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

  // ---------------------------------------------------------------------------
  // Read channel FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rd_state <= R_IDLE;
    else       rd_state <= rd_state_next;
  end

  always_comb begin
    rd_state_next = rd_state;
    ar_ready_o    = (rd_state == R_IDLE) & ~rst_i;
    r_valid_o     = (rd_state == R_RESP);
    ar_hs         = ar_valid_i & ar_ready_o;

    unique case (rd_state)
      R_IDLE:  if (ar_hs) rd_state_next = R_RESP;
      R_RESP:  if (r_ready_i) rd_state_next = R_IDLE;
      default: rd_state_next = R_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read datapath: sampled from the bank before any same-edge write lands
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_data_o <= '0;
      r_resp_o <= RESP_OKAY;
    end else if (ar_hs) begin
      r_data_o <= cfg_regs_o[reg_idx(ar_addr_i)*DATA_WIDTH +: DATA_WIDTH];
      r_resp_o <= RESP_OKAY;
    end
  end

endmodule
